// File: rtl/cdd_sector_tx.sv
// CD drive sector transmitter: frames 1176-word sectors (optional 12-byte sync
// header) from a word source and presents them as CD_D / CD_CK word strobes.
module cdd_sector_tx (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_2X,
    input  logic        SPD,
    input  logic        START,
    input  logic        MODE,
    input  logic [15:0] SRC_D,
    input  logic        SRC_VALID,
    output logic        SRC_READY,
    output logic [15:0] CD_D,
    output logic        CD_CK,
    output logic        BUSY,
    output logic        SECT_DONE,
    output logic [15:0] SECT_CNT,
    output logic        UNDERRUN,
    input  logic        UR_CLR
);

    localparam logic [10:0] LAST_WIDX = 11'd1175;
    localparam logic [10:0] SYNC_LAST = 11'd5;

    typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD} state_t;

    state_t      state;
    state_t      state_next;
    logic        div;
    logic [10:0] widx;
    logic        tick;
    logic        emit;
    logic        sector_end;
    logic [15:0] word;
    logic        ck_p1;
    logic        ck_p2;

    assign tick       = CE_2X & (SPD | div);
    assign sector_end = emit && (widx == LAST_WIDX);
    assign BUSY       = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // MODE is captured only by the choice of SYNC vs PAYLOAD when a sector begins.
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        SRC_READY  = 1'b0;
        word       = 16'h0000;
        case (state)
            IDLE: begin
                if (tick && START) begin
                    state_next = MODE ? SYNC : PAYLOAD;
                end
            end
            SYNC: begin
                if (tick) begin
                    emit = 1'b1;
                    case (widx)
                        11'd0:     word = 16'hFF00;
                        SYNC_LAST: word = 16'h00FF;
                        default:   word = 16'hFFFF;
                    endcase
                    if (widx == SYNC_LAST) begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (tick) begin
                    emit      = 1'b1;
                    SRC_READY = 1'b1;
                    word      = SRC_VALID ? SRC_D : 16'h0000;
                    if (widx == LAST_WIDX) begin
                        if (!START) begin
                            state_next = IDLE;
                        end else begin
                            state_next = MODE ? SYNC : PAYLOAD;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // CD_D may only return to zero once the last word's CD_CK pulse has finished.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div       <= 1'b0;
            widx      <= 11'd0;
            CD_D      <= 16'h0000;
            ck_p1     <= 1'b0;
            ck_p2     <= 1'b0;
            CD_CK     <= 1'b0;
            SECT_DONE <= 1'b0;
            SECT_CNT  <= 16'h0000;
            UNDERRUN  <= 1'b0;
        end else begin
            if (CE_2X) begin
                div <= ~div;
            end
            if (emit) begin
                CD_D <= word;
                widx <= sector_end ? 11'd0 : widx + 11'd1;
            end else if (state == IDLE && !ck_p1 && !CD_CK) begin
                CD_D <= 16'h0000;
            end
            ck_p1     <= emit;
            ck_p2     <= ck_p1;
            CD_CK     <= ck_p1 | ck_p2;
            SECT_DONE <= sector_end;
            if (sector_end) begin
                SECT_CNT <= SECT_CNT + 16'd1;
            end
            if (SRC_READY && !SRC_VALID) begin
                UNDERRUN <= 1'b1;
            end else if (UR_CLR) begin
                UNDERRUN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdd_sector_tx.sv
// Scoreboard bench for cdd_sector_tx: whole sectors of expected words are queued
// from a sector-level model and popped by a monitor on every CD_CK rising edge.
module tb_cdd_sector_tx;

    localparam int P = 5;

    logic        CLK;
    logic        RST;
    logic        CE_2X;
    logic        SPD;
    logic        START;
    logic        MODE;
    logic [15:0] SRC_D;
    logic        SRC_VALID;
    logic        SRC_READY;
    logic [15:0] CD_D;
    logic        CD_CK;
    logic        BUSY;
    logic        SECT_DONE;
    logic [15:0] SECT_CNT;
    logic        UNDERRUN;
    logic        UR_CLR;

    cdd_sector_tx dut (
        .CLK(CLK), .RST(RST), .CE_2X(CE_2X), .SPD(SPD), .START(START), .MODE(MODE),
        .SRC_D(SRC_D), .SRC_VALID(SRC_VALID), .SRC_READY(SRC_READY),
        .CD_D(CD_D), .CD_CK(CD_CK), .BUSY(BUSY), .SECT_DONE(SECT_DONE),
        .SECT_CNT(SECT_CNT), .UNDERRUN(UNDERRUN), .UR_CLR(UR_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_q[$];
    int          words_seen = 0;
    int          done_cnt = 0;
    bit          gap_chk = 0;
    int          exp_gap = 0;
    bit          have_last = 0;
    longint      cyc = 0;
    longint      last_edge = 0;
    logic        prev_ck = 1'b0;
    logic        prev_done = 1'b0;

    // Source side (driven by the handshake) and sector-level model side.
    int          rdy_cnt = 0;
    logic [15:0] src_cnt = 16'h0000;
    int          ur_lo = -10;
    int          ur_hi = -10;
    logic [15:0] model_src = 16'h0000;
    int          model_rc = 0;

    task automatic checkOutput(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    function automatic void driveSource();
        SRC_D     = src_cnt;
        SRC_VALID = !(rdy_cnt >= ur_lo && rdy_cnt <= ur_hi);
    endfunction

    // Expected words of one whole sector; payload words skipped by the source become zero.
    function automatic void pushSector(input bit data);
        int n;
        if (data) begin
            exp_q.push_back(16'hFF00);
            for (int i = 0; i < 4; i++) exp_q.push_back(16'hFFFF);
            exp_q.push_back(16'h00FF);
        end
        n = data ? 1170 : 1176;
        for (int k = 0; k < n; k++) begin
            if (model_rc >= ur_lo && model_rc <= ur_hi) begin
                exp_q.push_back(16'h0000);
            end else begin
                exp_q.push_back(model_src);
                model_src++;
            end
            model_rc++;
        end
    endfunction

    task automatic applyStimulus(input int n);
        logic rdy;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            CE_2X = 1'b1;
            #1 rdy = SRC_READY;
            @(negedge CLK);
            CE_2X = 1'b0;
            if (rdy) begin
                if (SRC_VALID) src_cnt++;
                rdy_cnt++;
            end
            driveSource();
            repeat (P - 2) @(negedge CLK);
        end
    endtask

    task automatic runUntilDone(input int target, input int max_ce, input string name);
        int n = 0;
        while (done_cnt < target && n < max_ce) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(name, done_cnt, target);
    endtask

    task automatic runUntilWords(input int target, input int max_ce, input string name);
        int n = 0;
        while (words_seen < target && n < max_ce) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(name, (words_seen >= target) ? 1 : 0, 1);
    endtask

    // Monitor: pops the scoreboard on each CD_CK rise, tracks spacing and SECT_DONE pulses.
    always @(negedge CLK) begin
        cyc++;
        if (CD_CK && !prev_ck) begin
            words_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_word actual=%h required=none", CD_D);
            end else begin
                checkOutput("cd_word", CD_D, exp_q.pop_front());
            end
            if (gap_chk && have_last) checkOutput("ck_spacing", cyc - last_edge, exp_gap);
            last_edge = cyc;
            have_last = 1;
        end
        if (prev_done) checkOutput("sect_done_width", SECT_DONE, 0);
        else if (SECT_DONE) done_cnt++;
        prev_ck   = CD_CK;
        prev_done = SECT_DONE;
    end

    initial begin
        repeat (95000) @(posedge CLK);
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_rdy;
        int base_w;
        int tgt;
        RST = 1'b1; CE_2X = 1'b0; SPD = 1'b0; START = 1'b0; MODE = 1'b0; UR_CLR = 1'b0;
        driveSource();
        repeat (3) @(negedge CLK);
        #1;
        checkOutput("rst_cd_d", CD_D, 0);
        checkOutput("rst_cd_ck", CD_CK, 0);
        checkOutput("rst_busy", BUSY, 0);
        checkOutput("rst_sect_cnt", SECT_CNT, 0);
        checkOutput("rst_underrun", UNDERRUN, 0);
        @(negedge CLK);
        RST = 1'b0;

        $display("[TB] data sector at 2x, source always valid");
        SPD = 1'b1; MODE = 1'b1; START = 1'b1;
        pushSector(1);
        base_rdy = rdy_cnt; base_w = words_seen; tgt = done_cnt + 1;
        applyStimulus(3);
        checkOutput("s1_busy", BUSY, 1);
        START = 1'b0;
        runUntilDone(tgt, 1300, "s1_done");
        applyStimulus(3);
        checkOutput("s1_ready_pulses", rdy_cnt - base_rdy, 1170);
        checkOutput("s1_words", words_seen - base_w, 1176);
        checkOutput("s1_sect_cnt", SECT_CNT, 1);
        checkOutput("s1_idle_busy", BUSY, 0);
        checkOutput("s1_idle_cd_d", CD_D, 0);
        checkOutput("s1_queue_empty", exp_q.size(), 0);

        $display("[TB] audio sector at 1x");
        SPD = 1'b0; MODE = 1'b0; START = 1'b1;
        pushSector(0);
        base_rdy = rdy_cnt; base_w = words_seen; tgt = done_cnt + 1;
        gap_chk = 1; have_last = 0; exp_gap = 2 * P;
        applyStimulus(4);
        START = 1'b0;
        runUntilDone(tgt, 2500, "s2_done");
        applyStimulus(4);
        gap_chk = 0;
        checkOutput("s2_ready_pulses", rdy_cnt - base_rdy, 1176);
        checkOutput("s2_words", words_seen - base_w, 1176);
        checkOutput("s2_sect_cnt", SECT_CNT, 2);
        checkOutput("s2_underrun", UNDERRUN, 0);
        checkOutput("s2_queue_empty", exp_q.size(), 0);

        $display("[TB] data sector with payload words 100..102 missing");
        SPD = 1'b1; MODE = 1'b1; START = 1'b1;
        ur_lo = model_rc + 100; ur_hi = model_rc + 102;
        driveSource();
        pushSector(1);
        base_w = words_seen; tgt = done_cnt + 1;
        applyStimulus(3);
        START = 1'b0;
        runUntilDone(tgt, 1300, "s3_done");
        applyStimulus(3);
        checkOutput("s3_words", words_seen - base_w, 1176);
        checkOutput("s3_underrun_set", UNDERRUN, 1);
        checkOutput("s3_sect_cnt", SECT_CNT, 3);
        checkOutput("s3_queue_empty", exp_q.size(), 0);
        ur_lo = -10; ur_hi = -10;
        driveSource();
        @(negedge CLK); UR_CLR = 1'b1;
        @(negedge CLK); UR_CLR = 1'b0;
        #1 checkOutput("s3_underrun_clr", UNDERRUN, 0);

        $display("[TB] back-to-back sectors, MODE and SPD changed mid-sector, stop at 500");
        SPD = 1'b1; MODE = 1'b0; START = 1'b1;
        pushSector(0);
        base_w = words_seen; tgt = done_cnt + 2;
        gap_chk = 1; have_last = 0; exp_gap = P;
        runUntilWords(base_w + 300, 400, "s4_reach_300");
        MODE = 1'b1;
        pushSector(1);
        runUntilWords(base_w + 1176 + 200, 1200, "s4_reach_2nd_200");
        SPD = 1'b0; exp_gap = 2 * P; have_last = 0;
        runUntilWords(base_w + 1176 + 500, 800, "s4_reach_2nd_500");
        START = 1'b0;
        runUntilDone(tgt, 2000, "s4_done");
        applyStimulus(6);
        gap_chk = 0;
        checkOutput("s4_words", words_seen - base_w, 2352);
        checkOutput("s4_sect_cnt", SECT_CNT, 5);
        checkOutput("s4_idle_busy", BUSY, 0);
        checkOutput("s4_idle_cd_d", CD_D, 0);
        checkOutput("s4_queue_empty", exp_q.size(), 0);
        base_w = words_seen;
        applyStimulus(10);
        checkOutput("s4_idle_quiet", words_seen - base_w, 0);
        checkOutput("s4_idle_ck", CD_CK, 0);

        $display("[TB] reset in the middle of a data sector");
        SPD = 1'b1; MODE = 1'b1; START = 1'b1;
        pushSector(1);
        base_w = words_seen;
        runUntilWords(base_w + 700, 800, "s5_reach_700");
        checkOutput("s5_busy_before", BUSY, 1);
        #2 RST = 1'b1;
        #1;
        checkOutput("s5_rst_cd_d", CD_D, 0);
        checkOutput("s5_rst_cd_ck", CD_CK, 0);
        checkOutput("s5_rst_busy", BUSY, 0);
        checkOutput("s5_rst_ready", SRC_READY, 0);
        checkOutput("s5_rst_done", SECT_DONE, 0);
        checkOutput("s5_rst_sect_cnt", SECT_CNT, 0);
        checkOutput("s5_rst_underrun", UNDERRUN, 0);
        exp_q.delete();
        src_cnt = 16'h4000; model_src = 16'h4000;
        rdy_cnt = 0; model_rc = 0;
        driveSource();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        pushSector(1);
        base_w = words_seen; tgt = done_cnt + 1;
        applyStimulus(3);
        START = 1'b0;
        runUntilDone(tgt, 1300, "s5_done");
        applyStimulus(3);
        checkOutput("s5_words", words_seen - base_w, 1176);
        checkOutput("s5_sect_cnt", SECT_CNT, 1);
        checkOutput("s5_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
